mips_multicycle_control: RTL and testbench

Multi-cycle sequencer for the MIPS core. It replaces single-cycle decode with an FSM that shares one ULA and one unified memory across the fetch, decode, execute, memory and write-back steps.
- Drives every datapath select and write enable.
- Resolves the PC update internally from the ULA zero flag.
- Stalls on a memory ready handshake.
- Counts retired instructions.
- Sits between i/d memory, regfile, ULA, PC mux and a new IR register.

---
 rtl/mips_multicycle_control_pkg.sv | 66 ++++++
 rtl/mips_mc_decode.sv | 145 ++++++++++++++
 rtl/mips_multicycle_control.sv | 97 +++++++++
 tb/tb_mips_multicycle_control.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
// Holds the FSM state encoding, the opcode constants decoded from IR[31:26],
// the ULA operation / operand-select / PC-source encodings, and the packed
// control vector passed from the decoder to the top.
package mips_multicycle_control_pkg;

    // FSM states with their fixed 4-bit debug encodings.
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11,
        ST_ILLEGAL   = 4'd12
    } state_t;

    // Supported opcodes (instruction[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // Operation codes handed to ula_control.
    localparam logic [2:0] ULA_ADD   = 3'b000;
    localparam logic [2:0] ULA_SUB   = 3'b001;
    localparam logic [2:0] ULA_FUNCT = 3'b010;

    // ULA operand B selects.
    localparam logic [1:0] SRC_B_REG      = 2'd0;
    localparam logic [1:0] SRC_B_FOUR     = 2'd1;
    localparam logic [1:0] SRC_B_SEXT     = 2'd2;
    localparam logic [1:0] SRC_B_SEXT_SH2 = 2'd3;

    // PC mux selects.
    localparam logic [1:0] PC_SRC_ULA     = 2'd0;
    localparam logic [1:0] PC_SRC_ULA_OUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP    = 2'd2;

    // Full set of datapath controls produced for one cycle.
    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       ula_src_a;
        logic [1:0] ula_src_b;
        logic [2:0] ula_operation;
        logic [1:0] pc_source;
        logic       instr_retired;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational decoder for the multi-cycle MIPS sequencer.
// Maps (current state, opcode, ula_zero, mem_ready) to the control vector for
// this cycle and the next FSM state. Selects depend on state only; the write
// strobes pc_write, ir_write and instr_retired are additionally qualified by
// mem_ready / ula_zero where the step needs it.
// Ports:
//   state      : current FSM state
//   opcode     : instruction[31:26] from IR
//   ula_zero   : ULA zero flag (branch resolution)
//   mem_ready  : memory access completes this cycle
//   ctrl       : control vector for this cycle (all fields 0 unless set)
//   next_state : state to load on the next rising edge
module mips_mc_decode
    import mips_multicycle_control_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       ula_zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl,
    output state_t     next_state
);

    // Per-state control vector and next-state selection.
    always_comb begin
        ctrl       = '0;
        next_state = state;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read      = 1'b1;
                ctrl.ula_src_b     = SRC_B_FOUR;
                ctrl.ula_operation = ULA_ADD;
                ctrl.pc_source     = PC_SRC_ULA;
                // IR and PC+4 are captured only once the fetch completes.
                if (mem_ready) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.ir_write = 1'b1;
                    next_state    = ST_DECODE;
                end else begin
                    next_state    = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // Branch target precomputed while the register file is read.
                ctrl.ula_src_b     = SRC_B_SEXT_SH2;
                ctrl.ula_operation = ULA_ADD;
                case (opcode)
                    OP_RTYPE:     next_state = ST_R_EXEC;
                    OP_LW, OP_SW: next_state = ST_MEM_ADDR;
                    OP_BEQ,
                    OP_BNE:       next_state = ST_BRANCH;
                    OP_J:         next_state = ST_JUMP;
                    OP_ADDI:      next_state = ST_ADDI_EXEC;
                    default:      next_state = ST_ILLEGAL;
                endcase
            end
            ST_MEM_ADDR: begin
                ctrl.ula_src_a     = 1'b1;
                ctrl.ula_src_b     = SRC_B_SEXT;
                ctrl.ula_operation = ULA_ADD;
                if (opcode == OP_SW) begin
                    next_state = ST_MEM_WRITE;
                end else begin
                    next_state = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    next_state = ST_MEM_WB;
                end else begin
                    next_state = ST_MEM_READ;
                end
            end
            ST_MEM_WB: begin
                ctrl.mem_to_reg    = 1'b1;
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
                next_state         = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
                if (mem_ready) begin
                    ctrl.instr_retired = 1'b1;
                    next_state         = ST_FETCH;
                end else begin
                    next_state         = ST_MEM_WRITE;
                end
            end
            ST_R_EXEC: begin
                ctrl.ula_src_a     = 1'b1;
                ctrl.ula_src_b     = SRC_B_REG;
                ctrl.ula_operation = ULA_FUNCT;
                next_state         = ST_R_WB;
            end
            ST_R_WB: begin
                ctrl.reg_dst       = 1'b1;
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
                next_state         = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.ula_src_a     = 1'b1;
                ctrl.ula_src_b     = SRC_B_REG;
                ctrl.ula_operation = ULA_SUB;
                ctrl.pc_source     = PC_SRC_ULA_OUT;
                ctrl.instr_retired = 1'b1;
                // bne takes the branch on a non-zero difference.
                if (opcode == OP_BNE) begin
                    ctrl.pc_write = ~ula_zero;
                end else begin
                    ctrl.pc_write = ula_zero;
                end
                next_state = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_source     = PC_SRC_JUMP;
                ctrl.pc_write      = 1'b1;
                ctrl.instr_retired = 1'b1;
                next_state         = ST_FETCH;
            end
            ST_ADDI_EXEC: begin
                ctrl.ula_src_a     = 1'b1;
                ctrl.ula_src_b     = SRC_B_SEXT;
                ctrl.ula_operation = ULA_ADD;
                next_state         = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
                next_state         = ST_FETCH;
            end
            ST_ILLEGAL: begin
                next_state = ST_ILLEGAL;
            end
            default: begin
                // Unused encodings are treated as a fault and parked.
                next_state = ST_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control sequencer. One shared ULA and one unified memory
// are time-multiplexed across fetch / decode / execute / memory / write-back.
// Holds the state register, the retired-instruction counter and the sticky
// illegal-opcode flag; per-cycle controls come from mips_mc_decode.
// Ports:
//   clock, reset (async, active-low)
//   opcode, ula_zero, mem_ready          : datapath / memory status inputs
//   pc_write .. pc_source                : datapath selects and write enables
//   instr_retired, retired_count         : retirement pulse and wrapping count
//   illegal                              : sticky unsupported-opcode flag
//   state                                : current FSM state (debug)
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic                ula_zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                ula_src_a,
    output logic [1:0]          ula_src_b,
    output logic [2:0]          ula_operation,
    output logic [1:0]          pc_source,
    output logic                instr_retired,
    output logic [RETIRE_W-1:0] retired_count,
    output logic                illegal,
    output logic [3:0]          state
);

    state_t              state_r;
    state_t              next_state_s;
    ctrl_t               ctrl_s;
    logic [RETIRE_W-1:0] count_r;
    logic                illegal_r;

    mips_mc_decode u_decode (
        .state      (state_r),
        .opcode     (opcode),
        .ula_zero   (ula_zero),
        .mem_ready  (mem_ready),
        .ctrl       (ctrl_s),
        .next_state (next_state_s)
    );

    // State register, retirement counter and sticky illegal flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_FETCH;
            count_r   <= {RETIRE_W{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (ctrl_s.instr_retired) begin
                count_r <= count_r + {{(RETIRE_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
            if (next_state_s == ST_ILLEGAL) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
        end
    end

    // Write enables are forced low while reset is held so an aborted
    // instruction cannot leave a partial update behind.
    assign pc_write      = ctrl_s.pc_write      & reset;
    assign mem_write     = ctrl_s.mem_write     & reset;
    assign ir_write      = ctrl_s.ir_write      & reset;
    assign reg_write     = ctrl_s.reg_write     & reset;
    assign instr_retired = ctrl_s.instr_retired & reset;

    assign i_or_d        = ctrl_s.i_or_d;
    assign mem_read      = ctrl_s.mem_read;
    assign reg_dst       = ctrl_s.reg_dst;
    assign mem_to_reg    = ctrl_s.mem_to_reg;
    assign ula_src_a     = ctrl_s.ula_src_a;
    assign ula_src_b     = ctrl_s.ula_src_b;
    assign ula_operation = ctrl_s.ula_operation;
    assign pc_source     = ctrl_s.pc_source;

    assign retired_count = count_r;
    assign illegal       = illegal_r;
    assign state         = state_r;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control (RETIRE_W=4).
// The stimulus process drives one directed cycle at a time and pushes the
// hand-derived expected outputs for that cycle; the monitor pops and compares
// on every falling edge.
module tb_mips_multicycle_control;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic       ula_zero;
    logic       mem_ready;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, ula_src_a;
    logic [1:0] ula_src_b;
    logic [2:0] ula_operation;
    logic [1:0] pc_source;
    logic       instr_retired;
    logic [3:0] retired_count;
    logic       illegal;
    logic [3:0] state;

    mips_multicycle_control #(.RETIRE_W(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .opcode        (opcode),
        .ula_zero      (ula_zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .ula_src_a     (ula_src_a),
        .ula_src_b     (ula_src_b),
        .ula_operation (ula_operation),
        .pc_source     (pc_source),
        .instr_retired (instr_retired),
        .retired_count (retired_count),
        .illegal       (illegal),
        .state         (state)
    );

    // strobes = {pc_write, ir_write, reg_write, mem_write, instr_retired}
    // moore   = {i_or_d, mem_read, reg_dst, mem_to_reg, ula_src_a,
    //            ula_src_b[1:0], ula_operation[2:0], pc_source[1:0]}
    typedef struct packed {
        logic [3:0]  st;
        logic [4:0]  strb;
        logic [11:0] moore;
        logic [3:0]  cnt;
        logic        ill;
    } exp_t;

    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_FETCH = 5'b11000;
    localparam logic [4:0] S_WB    = 5'b00101;
    localparam logic [4:0] S_MEMW  = 5'b00010;
    localparam logic [4:0] S_SWRET = 5'b00011;
    localparam logic [4:0] S_TAKEN = 5'b10001;
    localparam logic [4:0] S_RET   = 5'b00001;

    exp_t       sb_q[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         vec_idx    = 0;
    logic [3:0] exp_cnt    = 4'd0;
    logic       exp_ill    = 1'b0;
    logic       stim_done  = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Select values written out per state from the control table.
    function automatic logic [11:0] moore_exp(input logic [3:0] st);
        case (st)
            4'd0:    moore_exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'b000, 2'd0};
            4'd1:    moore_exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'b000, 2'd0};
            4'd2:    moore_exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000, 2'd0};
            4'd3:    moore_exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 2'd0};
            4'd4:    moore_exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000, 2'd0};
            4'd5:    moore_exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 2'd0};
            4'd6:    moore_exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'b010, 2'd0};
            4'd7:    moore_exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'b000, 2'd0};
            4'd8:    moore_exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'b001, 2'd1};
            4'd9:    moore_exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 2'd2};
            4'd10:   moore_exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000, 2'd0};
            default: moore_exp = 12'd0;
        endcase
    endfunction

    // One directed cycle: drive inputs just after the rising edge and queue
    // the outputs expected for the rest of that cycle.
    task automatic cyc(input logic rst, input logic [5:0] op, input logic z,
                       input logic rdy, input logic [3:0] st, input logic [4:0] strb);
        exp_t e;
        @(posedge clock);
        #1;
        reset     = rst;
        opcode    = op;
        ula_zero  = z;
        mem_ready = rdy;
        if (!rst) begin
            exp_cnt = 4'd0;
            exp_ill = 1'b0;
        end
        if (st == 4'd12) exp_ill = 1'b1;
        e.st    = st;
        e.strb  = strb;
        e.moore = moore_exp(st);
        e.cnt   = exp_cnt;
        e.ill   = exp_ill;
        sb_q.push_back(e);
        if (strb[0]) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want, inout logic bad);
        if (got !== want) begin
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, got, want);
            bad = 1'b1;
        end
    endtask

    // Monitor: compare every queued expectation against the DUT outputs.
    always @(negedge clock) begin
        exp_t e;
        logic bad;
        if (sb_q.size() != 0) begin
            e   = sb_q.pop_front();
            bad = 1'b0;
            chk("state", vec_idx, {28'd0, state}, {28'd0, e.st}, bad);
            chk("strobes", vec_idx,
                {27'd0, pc_write, ir_write, reg_write, mem_write, instr_retired},
                {27'd0, e.strb}, bad);
            chk("selects", vec_idx,
                {20'd0, i_or_d, mem_read, reg_dst, mem_to_reg, ula_src_a,
                 ula_src_b, ula_operation, pc_source},
                {20'd0, e.moore}, bad);
            chk("retired_count", vec_idx, {28'd0, retired_count}, {28'd0, e.cnt}, bad);
            chk("illegal", vec_idx, {31'd0, illegal}, {31'd0, e.ill}, bad);
            compared = compared + 1;
            if (bad) mismatched = mismatched + 1;
            vec_idx = vec_idx + 1;
        end else if (stim_done) begin
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        opcode    = 6'h00;
        ula_zero  = 1'b0;
        mem_ready = 1'b0;
        // Reset state with mem_ready high: no fetch writes may leak.
        cyc(1'b0, 6'h00, 1'b0, 1'b1, 4'd0, S_NONE);
        // R-type
        cyc(1'b1, 6'h00, 1'b0, 1'b1, 4'd0, S_FETCH);
        cyc(1'b1, 6'h00, 1'b0, 1'b1, 4'd1, S_NONE);
        cyc(1'b1, 6'h00, 1'b0, 1'b1, 4'd6, S_NONE);
        cyc(1'b1, 6'h00, 1'b0, 1'b1, 4'd7, S_WB);
        // lw aborted by reset while waiting in MEM_READ
        cyc(1'b1, 6'h23, 1'b0, 1'b1, 4'd0, S_FETCH);
        cyc(1'b1, 6'h23, 1'b0, 1'b1, 4'd1, S_NONE);
        cyc(1'b1, 6'h23, 1'b0, 1'b1, 4'd2, S_NONE);
        cyc(1'b1, 6'h23, 1'b0, 1'b0, 4'd3, S_NONE);
        cyc(1'b0, 6'h23, 1'b0, 1'b1, 4'd0, S_NONE);
        cyc(1'b0, 6'h23, 1'b0, 1'b1, 4'd0, S_NONE);
        // lw: 2 fetch waits, 3 read waits -> 10 cycles
        cyc(1'b1, 6'h23, 1'b0, 1'b0, 4'd0, S_NONE);
        cyc(1'b1, 6'h23, 1'b0, 1'b0, 4'd0, S_NONE);
        cyc(1'b1, 6'h23, 1'b0, 1'b1, 4'd0, S_FETCH);
        cyc(1'b1, 6'h23, 1'b0, 1'b0, 4'd1, S_NONE);
        cyc(1'b1, 6'h23, 1'b0, 1'b0, 4'd2, S_NONE);
        cyc(1'b1, 6'h23, 1'b0, 1'b0, 4'd3, S_NONE);
        cyc(1'b1, 6'h23, 1'b0, 1'b0, 4'd3, S_NONE);
        cyc(1'b1, 6'h23, 1'b0, 1'b0, 4'd3, S_NONE);
        cyc(1'b1, 6'h23, 1'b0, 1'b1, 4'd3, S_NONE);
        cyc(1'b1, 6'h23, 1'b0, 1'b0, 4'd4, S_WB);
        // sw with one write wait
        cyc(1'b1, 6'h2B, 1'b0, 1'b1, 4'd0, S_FETCH);
        cyc(1'b1, 6'h2B, 1'b0, 1'b1, 4'd1, S_NONE);
        cyc(1'b1, 6'h2B, 1'b0, 1'b1, 4'd2, S_NONE);
        cyc(1'b1, 6'h2B, 1'b0, 1'b0, 4'd5, S_MEMW);
        cyc(1'b1, 6'h2B, 1'b0, 1'b1, 4'd5, S_SWRET);
        // beq taken, bne not taken, bne taken, beq not taken
        cyc(1'b1, 6'h04, 1'b1, 1'b1, 4'd0, S_FETCH);
        cyc(1'b1, 6'h04, 1'b1, 1'b1, 4'd1, S_NONE);
        cyc(1'b1, 6'h04, 1'b1, 1'b1, 4'd8, S_TAKEN);
        cyc(1'b1, 6'h05, 1'b1, 1'b1, 4'd0, S_FETCH);
        cyc(1'b1, 6'h05, 1'b1, 1'b1, 4'd1, S_NONE);
        cyc(1'b1, 6'h05, 1'b1, 1'b1, 4'd8, S_RET);
        cyc(1'b1, 6'h05, 1'b0, 1'b1, 4'd0, S_FETCH);
        cyc(1'b1, 6'h05, 1'b0, 1'b1, 4'd1, S_NONE);
        cyc(1'b1, 6'h05, 1'b0, 1'b1, 4'd8, S_TAKEN);
        cyc(1'b1, 6'h04, 1'b0, 1'b1, 4'd0, S_FETCH);
        cyc(1'b1, 6'h04, 1'b0, 1'b1, 4'd1, S_NONE);
        cyc(1'b1, 6'h04, 1'b0, 1'b1, 4'd8, S_RET);
        // addi
        cyc(1'b1, 6'h08, 1'b0, 1'b1, 4'd0, S_FETCH);
        cyc(1'b1, 6'h08, 1'b0, 1'b1, 4'd1, S_NONE);
        cyc(1'b1, 6'h08, 1'b0, 1'b1, 4'd10, S_NONE);
        cyc(1'b1, 6'h08, 1'b0, 1'b1, 4'd11, S_WB);
        // j
        cyc(1'b1, 6'h02, 1'b0, 1'b1, 4'd0, S_FETCH);
        cyc(1'b1, 6'h02, 1'b0, 1'b1, 4'd1, S_NONE);
        cyc(1'b1, 6'h02, 1'b0, 1'b1, 4'd9, S_TAKEN);
        // Counter wrap: reset, then 17 jumps -> 15, 0, 1
        cyc(1'b0, 6'h02, 1'b0, 1'b1, 4'd0, S_NONE);
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 6'h02, 1'b0, 1'b1, 4'd0, S_FETCH);
            cyc(1'b1, 6'h02, 1'b0, 1'b1, 4'd1, S_NONE);
            cyc(1'b1, 6'h02, 1'b0, 1'b1, 4'd9, S_TAKEN);
        end
        // Unsupported opcode: terminal, no writes even with ready/zero high
        cyc(1'b1, 6'h3F, 1'b1, 1'b1, 4'd0, S_FETCH);
        cyc(1'b1, 6'h3F, 1'b1, 1'b1, 4'd1, S_NONE);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 6'h3F, 1'b1, 1'b1, 4'd12, S_NONE);
        end
        // Reset clears the sticky flag and the count
        cyc(1'b0, 6'h3F, 1'b1, 1'b1, 4'd0, S_NONE);
        stim_done = 1'b1;
    end

endmodule
